// File: rtl/mul16_cmp_sched_if.sv
// ============================================================================
// mul16_cmp_sched_if : operand, compressor and result bundle for the scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

interface mul16_cmp_sched_if;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_a;
  logic [15:0]  in_b;
  logic [255:0] cmp_heap;
  logic [32:0]  cmp_dst;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_p;
  logic         err;

  modport slave (
    input  in_valid, in_a, in_b, cmp_dst, out_ready,
    output in_ready, cmp_heap, out_valid, out_p, err
  );

  modport master (
    output in_valid, in_a, in_b, cmp_dst, out_ready,
    input  in_ready, cmp_heap, out_valid, out_p, err
  );
endinterface

`default_nettype wire

// File: rtl/mul16_cmp_sched.sv
// ============================================================================
// mul16_cmp_sched : partial-product heap generator, token tracker and
//                   credit-guarded result FIFO for a 16x16 compressor
// Rev 1.0
// ============================================================================
`default_nettype none

module mul16_cmp_sched #(
  parameter int CMP_LAT    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mul16_cmp_sched_if.slave     bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(FIFO_DEPTH + CMP_LAT + 2) + 1;

  function automatic int col_off(input int c);
    int s;
    s = 0;
    if (c <= 15) s = c * (c + 1) / 2;
    else begin
      s = 136;
      for (int k = 16; k < c; k++) s += 31 - k;
    end
    return s;
  endfunction

  logic [255:0]    w_pp;
  logic            w_accept;
  logic            w_wr;
  logic            w_pop;
  logic [SW-1:0]   w_inflight;
  logic [SW-1:0]   w_credit;

  logic [255:0]    r_heap;
  logic [CMP_LAT:0] r_tok;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_err;

  for (genvar c = 0; c < 31; c++) begin : g_col
    localparam int LO  = (c > 15) ? c - 15 : 0;
    localparam int HI  = (c < 15) ? c : 15;
    localparam int OFF = col_off(c);
    for (genvar i = LO; i <= HI; i++) begin : g_bit
      assign w_pp[OFF + i - LO] = bus.in_a[i] & bus.in_b[c - i];
    end
  end

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_wr     = r_tok[CMP_LAT];
  assign w_pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_heap <= '0;
    else     r_heap <= w_accept ? w_pp : '0;
  end

  if (CMP_LAT == 0) begin : g_tok_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tok <= '0;
      else     r_tok <= w_accept;
    end
  end else begin : g_tok_shift
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tok <= '0;
      else     r_tok <= {r_tok[CMP_LAT-1:0], w_accept};
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k <= CMP_LAT; k++) w_inflight = w_inflight + SW'(r_tok[k]);
  end

  // Credits count every token already committed, so a capture always has room.
  assign w_credit     = w_inflight + SW'(r_count);
  assign bus.in_ready = (w_credit < SW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.cmp_dst[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr && bus.cmp_dst[32]) r_err <= 1'b1;
    end
  end

  assign bus.cmp_heap  = r_heap;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_p     = bus.out_valid ? r_mem[r_rptr] : '0;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mul16_cmp_sched.sv
// ============================================================================
// tb_mul16_cmp_sched : directed checks of the scheduler at three latencies
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul16_cmp_sched;

  logic clk;
  logic rst;
  logic force_err;
  int   n_tests;
  int   n_fail;

  mul16_cmp_sched_if if0 ();
  mul16_cmp_sched_if if1 ();
  mul16_cmp_sched_if if2 ();

  mul16_cmp_sched #(.CMP_LAT(0), .FIFO_DEPTH(4)) u_d0 (.clk(clk), .rst(rst), .bus(if0));
  mul16_cmp_sched #(.CMP_LAT(1), .FIFO_DEPTH(4)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
  mul16_cmp_sched #(.CMP_LAT(2), .FIFO_DEPTH(8)) u_d2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference compressor: weight every heap bit by its column position.
  function automatic logic [32:0] compress(input logic [255:0] h);
    logic [32:0] s;
    int pos;
    int height;
    s   = '0;
    pos = 0;
    for (int c = 0; c < 31; c++) begin
      height = (c <= 15) ? c + 1 : 31 - c;
      for (int j = 0; j < height; j++) if (h[pos + j]) s = s + (33'd1 << c);
      pos += height;
    end
    return s;
  endfunction

  logic [32:0] r_s1  = '0;
  logic [32:0] r_s2a = '0;
  logic [32:0] r_s2b = '0;

  assign if0.cmp_dst = compress(if0.cmp_heap) | {force_err, 32'd0};
  always @(posedge clk) r_s1 <= compress(if1.cmp_heap);
  assign if1.cmp_dst = r_s1;
  always @(posedge clk) begin
    r_s2a <= compress(if2.cmp_heap);
    r_s2b <= r_s2a;
  end
  assign if2.cmp_dst = r_s2b;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp, input string tag);
    if0.in_a     = a;
    if0.in_b     = b;
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    chk({tag, "_v_early"}, if0.out_valid, 1'b0);
    step();
    chk({tag, "_v"}, if0.out_valid, 1'b1);
    chk({tag, "_p"}, if0.out_p, exp);
    step();
    chk({tag, "_v_after"}, if0.out_valid, 1'b0);
  endtask

  logic [255:0] exp_heap;
  int           acc;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    force_err = 1'b0;
    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", if0.out_valid, 1'b0);
    chk("rst_in_ready",  if0.in_ready,  1'b1);
    chk("rst_out_p",     if0.out_p,     32'd0);
    chk("rst_err",       if0.err,       1'b0);
    chk("rst_heap",      if0.cmp_heap,  256'd0);
    rst = 1'b0;
    step();

    op0(16'h0003, 16'h0005, 32'h0000000F, "mul_3x5");
    op0(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "mul_max");
    op0(16'h8000, 16'h0002, 32'h00010000, "mul_8000x2");
    chk("err_clean", if0.err, 1'b0);

    // Single corner partial product lands at column 15, offset 120.
    exp_heap     = 256'd1 << 120;
    if0.in_a     = 16'h0001;
    if0.in_b     = 16'h8000;
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    chk("heap_one_bit", if0.cmp_heap, exp_heap);
    step();
    chk("heap_bubble", if0.cmp_heap, 256'd0);
    chk("heap_prod_v", if0.out_valid, 1'b1);
    chk("heap_prod_p", if0.out_p, 32'h00008000);
    step();

    force_err = 1'b1;
    op0(16'd2, 16'd3, 32'd6, "err_op");
    force_err = 1'b0;
    chk("err_set", if0.err, 1'b1);
    op0(16'd4, 16'd5, 32'd20, "err_hold_op");
    chk("err_sticky", if0.err, 1'b1);

    for (int t = 1; t <= 12; t++) begin
      if (t <= 8) begin
        if2.in_valid = 1'b1;
        if2.in_a     = 16'(t);
        if2.in_b     = 16'(t + 1);
        chk("stream_ready", if2.in_ready, 1'b1);
      end else begin
        if2.in_valid = 1'b0;
      end
      step();
      if (t >= 4 && t <= 11) begin
        chk("stream_v", if2.out_valid, 1'b1);
        chk("stream_p", if2.out_p, 32'((t - 3) * (t - 2)));
      end else begin
        chk("stream_idle", if2.out_valid, 1'b0);
      end
    end

    if1.out_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      if (acc < 6) begin
        if1.in_valid = 1'b1;
        if1.in_a     = 16'(acc + 2);
        if1.in_b     = 16'd3;
      end else begin
        if1.in_valid = 1'b0;
      end
      if (if1.in_ready && if1.in_valid) acc++;
      step();
    end
    if1.in_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", if1.in_ready, 1'b0);
    chk("bp_v", if1.out_valid, 1'b1);
    chk("bp_head", if1.out_p, 32'd6);
    step();
    step();
    chk("bp_head_stable", if1.out_p, 32'd6);
    if1.out_ready = 1'b1;
    chk("bp_no_comb_ready", if1.in_ready, 1'b0);
    step();
    chk("bp_ready_back", if1.in_ready, 1'b1);
    chk("bp_drain1", if1.out_p, 32'd9);
    step();
    chk("bp_drain2", if1.out_p, 32'd12);
    step();
    chk("bp_drain3", if1.out_p, 32'd15);
    step();
    chk("bp_empty", if1.out_valid, 1'b0);

    if2.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if2.in_valid = 1'b1;
      if2.in_a     = 16'(k + 10);
      if2.in_b     = 16'd2;
      step();
    end
    if2.in_valid = 1'b0;
    chk("mid_buffered", if2.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_v", if2.out_valid, 1'b0);
    chk("mid_rst_ready", if2.in_ready, 1'b1);
    chk("mid_rst_p", if2.out_p, 32'd0);
    chk("err_cleared", if0.err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if2.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("no_stale", if2.out_valid, 1'b0);
    end
    if2.in_a     = 16'd7;
    if2.in_b     = 16'd9;
    if2.in_valid = 1'b1;
    step();
    if2.in_valid = 1'b0;
    step();
    chk("post_rst_wait1", if2.out_valid, 1'b0);
    step();
    chk("post_rst_wait2", if2.out_valid, 1'b0);
    step();
    chk("post_rst_v", if2.out_valid, 1'b1);
    chk("post_rst_p", if2.out_p, 32'd63);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
